puf_challenge_reader: RTL and testbench

Host-side initiator for the ring-oscillator PUF array. Accepts a base challenge from the host, drives it sequentially as NUM_BITS challenges (base, base+1, …) into a pair of RO counter banks, times each measurement window, compares the two settled counts, and returns an NUM_BITS-bit response word plus a tie count over a valid/ready handshake. Sits between the host/test controller and the PUF oscillator/counter fabric; it owns RO enable, counter clear and challenge selection, and replaces the purely combinational count comparison.

---
 rtl/puf_pkg.sv | 22 ++
 rtl/puf_window_timer.sv | 35 +++
 rtl/puf_challenge_reader.sv | 163 ++++++++++++++++
 tb/tb_puf_challenge_reader.sv | 420 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/puf_pkg.sv
// Shared types and constants for the ring-oscillator PUF challenge reader.
package puf_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_MEASURE,
        S_SETTLE,
        S_SAMPLE,
        S_DONE
    } puf_state_e;

    localparam int CHAL_W_DEF   = 5;
    localparam int CNT_W_DEF    = 8;
    localparam int CLEAR_CYCLES = 2;

    // Width needed to count 0..num_bits ties.
    function automatic int tie_w(input int num_bits);
        return $clog2(num_bits + 1);
    endfunction

endpackage

// File: rtl/puf_window_timer.sv
// Loadable down-counter: i_start loads i_load, o_done pulses in the cycle
// the count reaches zero, so a load of N-1 yields an N-cycle interval.
module puf_window_timer #(
    parameter int W = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_start,
    input  logic [W-1:0] i_load,
    output logic         o_done
);

    logic [W-1:0] r_cnt;
    logic         r_active;

    // rst_n is active-high on this block despite its name.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_cnt    <= '0;
            r_active <= 1'b0;
        end else if (i_start) begin
            r_cnt    <= i_load;
            r_active <= 1'b1;
        end else if (r_active) begin
            if (r_cnt == '0) begin
                r_active <= 1'b0;
            end else begin
                r_cnt <= r_cnt - W'(1);
            end
        end
    end

    assign o_done = r_active && (r_cnt == '0);

endmodule

// File: rtl/puf_challenge_reader.sv
// Sequences NUM_BITS challenges through the RO counter banks, compares the
// settled counts and returns a response word plus tie count over valid/ready.
module puf_challenge_reader
    import puf_pkg::*;
#(
    parameter int CHAL_W   = CHAL_W_DEF,
    parameter int CNT_W    = CNT_W_DEF,
    parameter int NUM_BITS = 8,
    parameter int WINDOW   = 1024,
    parameter int SETTLE   = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic [CHAL_W-1:0]             req_challenge,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [NUM_BITS-1:0]           rsp_data,
    output logic [tie_w(NUM_BITS)-1:0]    rsp_ties,
    output logic [CHAL_W-1:0]             puf_challenge,
    output logic                          ro_en,
    output logic                          cnt_clr,
    input  logic [CNT_W-1:0]              count_a,
    input  logic [CNT_W-1:0]              count_b,
    output logic                          busy
);

    localparam int TIE_W   = tie_w(NUM_BITS);
    localparam int IDX_W   = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;
    localparam int TMR_MAX = (WINDOW > SETTLE) ? WINDOW : SETTLE;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    localparam logic [TMR_W-1:0] LD_CLEAR  = TMR_W'(CLEAR_CYCLES - 1);
    localparam logic [TMR_W-1:0] LD_WINDOW = TMR_W'(WINDOW - 1);
    localparam logic [TMR_W-1:0] LD_SETTLE = TMR_W'(SETTLE - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_BITS - 1);

    puf_state_e          r_state;
    puf_state_e          w_next;
    logic [CHAL_W-1:0]   r_chal;
    logic [IDX_W-1:0]    r_idx;
    logic [NUM_BITS-1:0] r_data;
    logic [TIE_W-1:0]    r_ties;

    logic                w_accept;
    logic                w_last;
    logic                w_bit;
    logic                w_tie;
    logic                w_tmr_start;
    logic [TMR_W-1:0]    w_tmr_load;
    logic                w_tmr_done;

    assign w_accept = req_valid && req_ready;
    assign w_last   = (r_idx == LAST_IDX);
    assign w_bit    = (count_a > count_b);
    assign w_tie    = (count_a == count_b);

    puf_window_timer #(
        .W (TMR_W)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_start (w_tmr_start),
        .i_load  (w_tmr_load),
        .o_done  (w_tmr_done)
    );

    // NOTE: every combinational output gets a default before the case so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        w_next      = r_state;
        w_tmr_start = 1'b0;
        w_tmr_load  = LD_CLEAR;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next      = S_CLEAR;
                    w_tmr_start = 1'b1;
                end
            end
            S_CLEAR: begin
                if (w_tmr_done) begin
                    w_next      = S_MEASURE;
                    w_tmr_start = 1'b1;
                    w_tmr_load  = LD_WINDOW;
                end
            end
            S_MEASURE: begin
                if (w_tmr_done) begin
                    w_next      = S_SETTLE;
                    w_tmr_start = 1'b1;
                    w_tmr_load  = LD_SETTLE;
                end
            end
            S_SETTLE: begin
                if (w_tmr_done) begin
                    w_next = S_SAMPLE;
                end
            end
            S_SAMPLE: begin
                if (w_last) begin
                    w_next = S_DONE;
                end else begin
                    w_next      = S_CLEAR;
                    w_tmr_start = 1'b1;
                end
            end
            S_DONE: begin
                if (rsp_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_state <= S_IDLE;
            r_chal  <= '0;
            r_idx   <= '0;
            r_data  <= '0;
            r_ties  <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_chal <= req_challenge;
                        r_idx  <= '0;
                        r_data <= '0;
                        r_ties <= '0;
                    end
                end
                S_SAMPLE: begin
                    r_data[r_idx] <= w_bit;
                    if (w_tie) begin
                        r_ties <= r_ties + TIE_W'(1);
                    end
                    // Challenge advances (and wraps) only when another bit follows.
                    if (!w_last) begin
                        r_idx  <= r_idx + IDX_W'(1);
                        r_chal <= r_chal + CHAL_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign req_ready     = (r_state == S_IDLE) && !rst_n;
    assign rsp_valid     = (r_state == S_DONE);
    assign rsp_data      = r_data;
    assign rsp_ties      = r_ties;
    assign puf_challenge = r_chal;
    assign ro_en         = (r_state == S_MEASURE);
    assign cnt_clr       = (r_state == S_IDLE) || (r_state == S_CLEAR) || (r_state == S_DONE);
    assign busy          = (r_state != S_IDLE);

endmodule

// File: tb/tb_puf_challenge_reader.sv
// Randomized bench for puf_challenge_reader with a rate-based RO bank model
// and a response model computed directly from per-challenge rates.
module tb_puf_challenge_reader;

    localparam int CHAL_W   = 5;
    localparam int CNT_W    = 8;
    localparam int NUM_BITS = 8;
    localparam int WINDOW   = 16;
    localparam int SETTLE   = 4;
    localparam int P        = WINDOW + SETTLE + 3;
    localparam int LAT      = NUM_BITS * P;
    localparam int NCHAL    = 1 << CHAL_W;
    localparam int TIE_W    = $clog2(NUM_BITS + 1);

    logic                clk;
    logic                rst_n;
    logic                req_valid;
    logic                req_ready;
    logic [CHAL_W-1:0]   req_challenge;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [NUM_BITS-1:0] rsp_data;
    logic [TIE_W-1:0]    rsp_ties;
    logic [CHAL_W-1:0]   puf_challenge;
    logic                ro_en;
    logic                cnt_clr;
    logic [CNT_W-1:0]    count_a;
    logic [CNT_W-1:0]    count_b;
    logic                busy;

    int total = 0;
    int bad   = 0;

    int ra [NCHAL];
    int rb [NCHAL];

    puf_challenge_reader #(
        .CHAL_W   (CHAL_W),
        .CNT_W    (CNT_W),
        .NUM_BITS (NUM_BITS),
        .WINDOW   (WINDOW),
        .SETTLE   (SETTLE)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_challenge (req_challenge),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_data      (rsp_data),
        .rsp_ties      (rsp_ties),
        .puf_challenge (puf_challenge),
        .ro_en         (ro_en),
        .cnt_clr       (cnt_clr),
        .count_a       (count_a),
        .count_b       (count_b),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RO banks: each counter advances by its challenge's rate per enabled cycle.
    logic [CNT_W-1:0] cnt_a = '0;
    logic [CNT_W-1:0] cnt_b = '0;
    always @(posedge clk) begin
        if (cnt_clr === 1'b1) begin
            cnt_a <= '0;
            cnt_b <= '0;
        end else if (ro_en === 1'b1) begin
            cnt_a <= cnt_a + CNT_W'(ra[puf_challenge]);
            cnt_b <= cnt_b + CNT_W'(rb[puf_challenge]);
        end
    end
    assign count_a = cnt_a;
    assign count_b = cnt_b;

    // Passive monitor: ro_en-high run lengths, cnt_clr-low run lengths and
    // the challenge present when each measurement begins.
    int              q_ro  [$];
    int              q_clr [$];
    logic [CHAL_W-1:0] q_chal [$];
    int              mon_ro_run  = 0;
    int              mon_clr_run = 0;
    logic            mon_prev_clr = 1'b1;
    initial begin
        forever begin
            @(negedge clk);
            if (ro_en === 1'b1) mon_ro_run++;
            else if (mon_ro_run > 0) begin
                q_ro.push_back(mon_ro_run);
                mon_ro_run = 0;
            end
            if (cnt_clr === 1'b0) begin
                if (mon_prev_clr === 1'b1) q_chal.push_back(puf_challenge);
                mon_clr_run++;
            end else if (mon_clr_run > 0) begin
                q_clr.push_back(mon_clr_run);
                mon_clr_run = 0;
            end
            mon_prev_clr = cnt_clr;
        end
    end

    initial begin
        #(500_000);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Response model: bit i is 1 when bank A runs faster on challenge base+i.
    function automatic void model(input int base, output logic [NUM_BITS-1:0] d, output int t);
        d = '0;
        t = 0;
        for (int i = 0; i < NUM_BITS; i++) begin
            int c;
            c = (base + i) % NCHAL;
            if (ra[c] > rb[c]) d[i] = 1'b1;
            if (ra[c] == rb[c]) t++;
        end
    endfunction

    task automatic set_gt(input int c);
        ra[c % NCHAL] = $urandom_range(8, 15);
        rb[c % NCHAL] = $urandom_range(1, 7);
    endtask

    task automatic set_lt(input int c);
        ra[c % NCHAL] = $urandom_range(1, 7);
        rb[c % NCHAL] = $urandom_range(8, 15);
    endtask

    task automatic set_eq(input int c);
        ra[c % NCHAL] = $urandom_range(1, 15);
        rb[c % NCHAL] = ra[c % NCHAL];
    endtask

    task automatic set_random_all();
        for (int c = 0; c < NCHAL; c++) begin
            if ($urandom_range(0, 1) == 1) set_gt(c);
            else set_lt(c);
        end
    endtask

    task automatic clear_mon();
        q_ro.delete();
        q_clr.delete();
        q_chal.delete();
    endtask

    // Issues one request; returns the cycle offset (from the accept edge) at
    // which rsp_valid is first seen, or -1 if it never arrives. Ends at a negedge.
    task automatic run_req(input logic [CHAL_W-1:0] base, output int lat);
        int  k;
        bit  seen;
        lat = -1;
        k = 0;
        @(negedge clk);
        while (req_ready !== 1'b1 && k < 100) begin
            @(negedge clk);
            k++;
        end
        req_valid     = 1'b1;
        req_challenge = base;
        @(posedge clk);
        #1 req_valid = 1'b0;
        k = 0;
        seen = 1'b0;
        while (!seen && k <= LAT + 50) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) begin
                seen = 1'b1;
                lat  = k;
            end else begin
                @(posedge clk);
                k++;
            end
        end
    endtask

    task automatic finish_rsp();
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
    endtask

    task automatic check_timing(input logic [CHAL_W-1:0] base);
        total++;
        if (q_ro.size() != NUM_BITS) begin
            bad++; $display("FAIL ro_runs count got=%0d want=%0d", q_ro.size(), NUM_BITS);
        end
        total++;
        if (q_clr.size() != NUM_BITS) begin
            bad++; $display("FAIL clr_runs count got=%0d want=%0d", q_clr.size(), NUM_BITS);
        end
        for (int i = 0; i < q_ro.size(); i++) begin
            total++;
            if (q_ro[i] != WINDOW) begin
                bad++; $display("FAIL ro_en_len bit%0d got=%0d want=%0d", i, q_ro[i], WINDOW);
            end
        end
        for (int i = 0; i < q_clr.size(); i++) begin
            total++;
            if (q_clr[i] != WINDOW + SETTLE + 1) begin
                bad++; $display("FAIL clr_low_len bit%0d got=%0d want=%0d", i, q_clr[i], WINDOW + SETTLE + 1);
            end
        end
        for (int i = 0; i < q_chal.size(); i++) begin
            total++;
            if (q_chal[i] !== CHAL_W'((int'(base) + i) % NCHAL)) begin
                bad++; $display("FAIL chal_seq bit%0d got=%h want=%h", i, q_chal[i], CHAL_W'((int'(base) + i) % NCHAL));
            end
        end
    endtask

    task automatic check_idle(input string tag);
        @(negedge clk);
        total++;
        if (req_ready !== 1'b1 || busy !== 1'b0 || rsp_valid !== 1'b0) begin
            bad++;
            $display("FAIL %s_idle got ready=%b busy=%b valid=%b want 1/0/0", tag, req_ready, busy, rsp_valid);
        end
    endtask

    task automatic check_rsp(input string tag, input logic [CHAL_W-1:0] base, input int lat);
        logic [NUM_BITS-1:0] d;
        int t;
        model(int'(base), d, t);
        total++;
        if (lat != LAT) begin
            bad++; $display("FAIL %s_latency got=%0d want=%0d", tag, lat, LAT);
        end
        total++;
        if (rsp_data !== d) begin
            bad++; $display("FAIL %s_data got=%h want=%h", tag, rsp_data, d);
        end
        total++;
        if (rsp_ties !== TIE_W'(t)) begin
            bad++; $display("FAIL %s_ties got=%0d want=%0d", tag, rsp_ties, t);
        end
        total++;
        if (puf_challenge !== CHAL_W'((int'(base) + NUM_BITS - 1) % NCHAL)) begin
            bad++; $display("FAIL %s_last_chal got=%h want=%h", tag, puf_challenge,
                            CHAL_W'((int'(base) + NUM_BITS - 1) % NCHAL));
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        req_valid = 1'b0;
        req_challenge = '0;
        rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++; if (ro_en !== 1'b0)         begin bad++; $display("FAIL rst_ro_en got=%b want=0", ro_en); end
        total++; if (cnt_clr !== 1'b1)       begin bad++; $display("FAIL rst_cnt_clr got=%b want=1", cnt_clr); end
        total++; if (puf_challenge !== '0)   begin bad++; $display("FAIL rst_chal got=%h want=0", puf_challenge); end
        total++; if (rsp_valid !== 1'b0)     begin bad++; $display("FAIL rst_rsp_valid got=%b want=0", rsp_valid); end
        total++; if (rsp_data !== '0)        begin bad++; $display("FAIL rst_rsp_data got=%h want=0", rsp_data); end
        total++; if (rsp_ties !== '0)        begin bad++; $display("FAIL rst_rsp_ties got=%h want=0", rsp_ties); end
        total++; if (busy !== 1'b0)          begin bad++; $display("FAIL rst_busy got=%b want=0", busy); end
        total++; if (req_ready !== 1'b0)     begin bad++; $display("FAIL rst_req_ready got=%b want=0", req_ready); end
        @(posedge clk);
        #1 rst_n = 1'b0;
        check_idle("post_reset");
    endtask

    task automatic test_all_ones();
        int lat;
        for (int c = 0; c < NCHAL; c++) set_gt(c);
        clear_mon();
        run_req(5'h00, lat);
        check_rsp("all_ones", 5'h00, lat);
        finish_rsp();
        check_timing(5'h00);
        check_idle("all_ones");
    endtask

    task automatic test_wrap();
        int lat;
        for (int c = 0; c < NCHAL; c++) set_lt(c);
        set_gt(5'h1C);
        set_gt(5'h1E);
        set_gt(5'h00);
        clear_mon();
        run_req(5'h1C, lat);
        check_rsp("wrap", 5'h1C, lat);
        finish_rsp();
        check_timing(5'h1C);
        check_idle("wrap");
    endtask

    task automatic test_ties();
        int lat;
        logic [CHAL_W-1:0] base;
        base = CHAL_W'($urandom_range(0, NCHAL - 1));
        set_random_all();
        set_eq(int'(base) + 1);
        set_eq(int'(base) + 6);
        // Ready already high before the response exists must not disturb it.
        rsp_ready = 1'b1;
        clear_mon();
        run_req(base, lat);
        check_rsp("ties", base, lat);
        total++;
        if (rsp_ties !== TIE_W'(2)) begin
            bad++; $display("FAIL ties_count got=%0d want=2", rsp_ties);
        end
        total++;
        if (rsp_data[1] !== 1'b0 || rsp_data[6] !== 1'b0) begin
            bad++; $display("FAIL ties_bits got=%b%b want=00", rsp_data[6], rsp_data[1]);
        end
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        check_idle("ties");
    endtask

    task automatic test_backpressure();
        int lat;
        int errs;
        logic [CHAL_W-1:0] base;
        logic [CHAL_W-1:0] base2;
        logic [NUM_BITS-1:0] d;
        int t;
        base  = CHAL_W'($urandom_range(0, NCHAL - 1));
        base2 = base + CHAL_W'(11);
        set_random_all();
        run_req(base, lat);
        check_rsp("bp", base, lat);
        model(int'(base), d, t);
        errs = 0;
        for (int i = 0; i < 50; i++) begin
            if (i == 10) begin
                req_valid = 1'b1;
                req_challenge = base2;
            end
            if (i == 20) req_valid = 1'b0;
            @(negedge clk);
            total++;
            if (rsp_valid !== 1'b1 || rsp_data !== d || req_ready !== 1'b0 || busy !== 1'b1) begin
                bad++;
                $display("FAIL bp_hold cyc%0d got valid=%b data=%h ready=%b busy=%b want 1/%h/0/1",
                         i, rsp_valid, rsp_data, req_ready, busy, d);
            end
        end
        total++;
        if (puf_challenge !== CHAL_W'((int'(base) + NUM_BITS - 1) % NCHAL)) begin
            bad++; $display("FAIL bp_ignored_req chal got=%h", puf_challenge);
        end
        finish_rsp();
        check_idle("bp");
        set_random_all();
        clear_mon();
        run_req(base2, lat);
        check_rsp("bp_next", base2, lat);
        finish_rsp();
        check_timing(base2);
        check_idle("bp_next");
    endtask

    task automatic test_reset_mid();
        int lat;
        int k;
        int seen;
        logic [CHAL_W-1:0] base;
        base = CHAL_W'($urandom_range(0, NCHAL - 1));
        set_random_all();
        @(negedge clk);
        req_valid = 1'b1;
        req_challenge = base;
        @(posedge clk);
        #1 req_valid = 1'b0;
        // Bit 3 measurement spans offsets 3P+2 .. 3P+1+WINDOW.
        for (k = 0; k < 3 * P + 7; k++) @(posedge clk);
        @(negedge clk);
        total++;
        if (ro_en !== 1'b1) begin
            bad++; $display("FAIL mid_in_measure got ro_en=%b want=1", ro_en);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        total++;
        if (ro_en !== 1'b0 || cnt_clr !== 1'b1 || busy !== 1'b0 || rsp_valid !== 1'b0) begin
            bad++;
            $display("FAIL mid_abort got ro_en=%b clr=%b busy=%b valid=%b want 0/1/0/0",
                     ro_en, cnt_clr, busy, rsp_valid);
        end
        #1 clear_mon();
        seen = 0;
        for (int i = 0; i < LAT + 20; i++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0 || busy !== 1'b0) seen++;
        end
        total++;
        if (seen != 0) begin
            bad++; $display("FAIL mid_no_rsp got=%0d active cycles want=0", seen);
        end
        clear_mon();
        run_req(base, lat);
        check_rsp("mid_fresh", base, lat);
        finish_rsp();
        check_timing(base);
        check_idle("mid_fresh");
    endtask

    initial begin
        test_reset();
        test_all_ones();
        test_wrap();
        test_ties();
        test_backpressure();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
